// File: rtl/mul_iter_if.sv
// Handshake and operand/result bundle between the EX stage and the iterative multiplier.
interface mul_iter_if #(
  parameter int unsigned DATA_LEN = 32
);
  logic                start_i;
  logic                flush_i;
  logic [DATA_LEN-1:0] data1_i;
  logic [DATA_LEN-1:0] data2_i;
  logic                busy_o;
  logic                valid_o;
  logic [DATA_LEN-1:0] data_o;
  logic                Zero_o;

  modport master (
    output start_i, flush_i, data1_i, data2_i,
    input  busy_o, valid_o, data_o, Zero_o
  );

  modport slave (
    input  start_i, flush_i, data1_i, data2_i,
    output busy_o, valid_o, data_o, Zero_o
  );
endinterface

// File: rtl/mul_iter_unit.sv
// Shift-add multiplier: one multiplier bit per cycle, returns low DATA_LEN bits of the product.
module mul_iter_unit #(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  mul_iter_if.slave bus
);
  localparam int unsigned CntW = $clog2(DATA_LEN + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] mcand_q, mcand_d;
  logic [DATA_LEN-1:0] mplier_q, mplier_d;
  logic [DATA_LEN-1:0] acc_q, acc_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                zero_q, zero_d;
  logic [DATA_LEN-1:0] acc_sum;
  logic                accept;
  logic                last_step;

  // Flush wins over start; DONE accepts a new start for back-to-back issue.
  assign accept    = bus.start_i && !bus.flush_i && (state_q == StIdle || state_q == StDone);
  assign last_step = (cnt_q == CntW'(1));
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StRun;
      StRun: begin
        if (bus.flush_i) begin
          state_d = StIdle;
        end else if (last_step) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    zero_d   = zero_q;
    if (accept) begin
      mcand_d  = bus.data1_i;
      mplier_d = bus.data2_i;
      acc_d    = '0;
      cnt_d    = CntW'(DATA_LEN);
    end else if (state_q == StRun && !bus.flush_i) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntW'(1);
      // Result is committed only on the edge that enters DONE.
      if (last_step) begin
        data_d = acc_sum;
        zero_d = (acc_sum == '0);
      end
    end
  end

  always_comb begin
    bus.busy_o  = (state_q == StRun);
    bus.valid_o = (state_q == StDone);
    bus.data_o  = data_q;
    bus.Zero_o  = zero_q;
  end
endmodule
